ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the registered operands (RD1_out, RD2_out) and a decoded mult/div opcode. It runs a 32-iteration shift-add multiply or restoring divide and owns the architectural HI/LO registers. While an operation is in flight it raises `busy`, which the hazard unit uses to stall the front end.

---
 rtl/ex_muldiv.sv | 169 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative 32-step multiply / restoring divide for the EX stage.
// Owns the architectural HI/LO registers and raises busy while an operation is in flight.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; MTHI/MTLO writes land here
// S_RUN  | one shift-add or restoring-subtract step per cycle
// S_FIX  | apply result signs, write HI/LO, pulse done
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]      cnt;
    logic               op_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_orig;
    logic [2*WIDTH-1:0] acc;

    logic               accept;
    logic               signed_op;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   div_lo;
    logic [WIDTH-1:0]   div_hi;

    assign accept    = (state == S_IDLE) && start && !flush;
    assign signed_op = ~op[0];
    assign sign_a    = signed_op & a[WIDTH-1];
    assign sign_b    = signed_op & b[WIDTH-1];
    assign abs_a     = sign_a ? (~a + 1'b1) : a;
    assign abs_b     = sign_b ? (~b + 1'b1) : b;

    // Multiply: accumulator upper half collects partial sums, lower half shifts out the multiplier.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc[WIDTH-2:0], div_ge};

    assign prod_fix = neg_res ? (~acc + 1'b1) : acc;
    assign quot     = acc[WIDTH-1:0];
    assign rem      = acc[2*WIDTH-1:WIDTH];
    assign div_lo   = div_zero ? '1 : (neg_res ? (~quot + 1'b1) : quot);
    assign div_hi   = div_zero ? a_orig : (neg_rem ? (~rem + 1'b1) : rem);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) next_state = S_RUN;
                S_RUN:   if (cnt == LAST) next_state = S_FIX;
                S_FIX:   next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            a_orig   <= '0;
            acc      <= '0;
        end else if (accept) begin
            cnt      <= '0;
            op_div   <= op[1];
            neg_res  <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            div_zero <= (b == '0);
            a_orig   <= a;
            if (op[1]) begin
                opnd <= abs_b;
                acc  <= {{WIDTH{1'b0}}, abs_a};
            end else begin
                opnd <= abs_a;
                acc  <= {{WIDTH{1'b0}}, abs_b};
            end
        end else if (state == S_RUN) begin
            cnt <= cnt + 1'b1;
            acc <= op_div ? div_next : mul_next;
        end
    end

    // A write strobe coinciding with an accepted start lands first and is replaced in FIX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi   <= '0;
            lo   <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (next_state != S_IDLE);
            done <= (state == S_FIX) && !flush;
            if ((state == S_FIX) && !flush) begin
                if (op_div) begin
                    hi <= div_hi;
                    lo <= div_lo;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end else if (state == S_IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: latency, signs, divide corners, flush, reset, MTHI/MTLO.
module tb_ex_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    ex_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in cycle 0 (after a negedge); returns in cycle 34 with results checked.
    task automatic run_op(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] eh, input logic [31:0] el, input string tag);
        start = 1'b1;
        op    = o;
        a     = ia;
        b     = ib;
        step();
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk({tag, " busy c1"}, 64'(busy), 64'd1);
        chk({tag, " done c1"}, 64'(done), 64'd0);
        repeat (32) step();
        chk({tag, " busy c33"}, 64'(busy), 64'd1);
        chk({tag, " done c33"}, 64'(done), 64'd0);
        step();
        chk({tag, " busy c34"}, 64'(busy), 64'd0);
        chk({tag, " done c34"}, 64'(done), 64'd1);
        chk({tag, " hi"}, 64'(hi), 64'(eh));
        chk({tag, " lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;

        step();
        step();
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        rst = 1'b1;
        step();
        step();
        chk("idle busy", 64'(busy), 64'd0);
        chk("idle hi", 64'(hi), 64'd0);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu max");
        step();
        chk("multu max done c35", 64'(done), 64'd0);

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult neg");
        run_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, "multu b2b");
        step();
        chk("b2b done c69", 64'(done), 64'd0);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div neg");
        run_op(OP_DIVU, 32'd64, 32'd7, 32'd1, 32'd9, "divu 64/7");
        run_op(OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, "divu by0");
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div by0");
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div ovf");
        step();

        // start and MTHI while busy must both be ignored
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        step();
        start = 1'b0;
        repeat (4) step();
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd5;
        b     = 32'd5;
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        step();
        start = 1'b0;
        hi_we = 1'b0;
        repeat (27) step();
        chk("ignore busy c33", 64'(busy), 64'd1);
        chk("ignore done c33", 64'(done), 64'd0);
        step();
        chk("ignore done c34", 64'(done), 64'd1);
        chk("ignore hi", 64'(hi), 64'd2);
        chk("ignore lo", 64'(lo), 64'd14);
        step();

        // flush at cycle 10
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd3;
        b     = 32'd3;
        step();
        start = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush busy c11", 64'(busy), 64'd0);
        for (int i = 0; i < 30; i++) begin
            chk("flush no done", 64'(done), 64'd0);
            step();
        end
        chk("flush hi kept", 64'(hi), 64'd2);
        chk("flush lo kept", 64'(lo), 64'd14);

        // flush beats a same-cycle start in IDLE
        start = 1'b1;
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        chk("flush vs start busy", 64'(busy), 64'd0);
        step();
        chk("flush vs start busy2", 64'(busy), 64'd0);

        // asynchronous reset mid-RUN
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd9;
        b     = 32'd9;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("pre-reset busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("async rst busy", 64'(busy), 64'd0);
        chk("async rst done", 64'(done), 64'd0);
        chk("async rst hi", 64'(hi), 64'd0);
        chk("async rst lo", 64'(lo), 64'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            chk("post-rst quiet done", 64'(done), 64'd0);
            step();
        end
        chk("post-rst busy", 64'(busy), 64'd0);
        chk("post-rst hi", 64'(hi), 64'd0);

        // MTHI / MTLO in IDLE
        hi_we = 1'b1;
        wdata = 32'hCAFE_F00D;
        step();
        hi_we = 1'b0;
        chk("mthi hi", 64'(hi), 64'hCAFE_F00D);
        chk("mthi lo", 64'(lo), 64'd0);
        lo_we = 1'b1;
        wdata = 32'h1234_5678;
        step();
        lo_we = 1'b0;
        chk("mtlo lo", 64'(lo), 64'h1234_5678);
        chk("mtlo hi", 64'(hi), 64'hCAFE_F00D);

        // write strobe with an accepted start: written, then overwritten by the result
        hi_we = 1'b1;
        wdata = 32'h0000_0055;
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd2;
        b     = 32'd3;
        step();
        start = 1'b0;
        hi_we = 1'b0;
        chk("we+start hi c1", 64'(hi), 64'h55);
        repeat (33) step();
        chk("we+start done", 64'(done), 64'd1);
        chk("we+start hi", 64'(hi), 64'd0);
        chk("we+start lo", 64'(lo), 64'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
